cpu_bus_ctrl: RTL and testbench
===============================

Name: cpu_bus_ctrl

Overview:
- Parametrised next-generation 68040-style CPU bus slave. It converts CPU transfer starts into the SoC request, write and read streams, and drives TA/TEA back to the CPU.
- Extends the first-generation interface with:
  - configurable data width and line burst length;
  - configurable boot-ROM remap count;
  - a bus-error (TEA) path from downstream errors and from a watchdog timeout.
- Sits between the pad/phase logic (bclk-aligned strobes) and the memory crossbar.

Parameters:
- DW, 32: data bus width; 32 or 64.
- AW, 32: address width.
- LINE_BEATS, 4: beats per SIZ_LINE burst; range 2..15.
- BOOT_ACCESSES, 2: number of transfers after reset remapped to ROM; 0 disables.
- ROM_OFF, 16'hF000: upper AW-16 address bits substituted during boot remap.
- TIMEOUT, 255: drv_i strobes allowed while waiting on req_ready or read_valid; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- samp_i  in  1  one-cycle strobe: CPU outputs are stable (bclk phase 0).
- drv_i  in  1  one-cycle strobe: CPU-side outputs may change (bclk phase 1).
- cpu_ts_n  in  1  transfer start, active low.
- cpu_tt  in  2  transfer type.
- cpu_siz  in  2  transfer size.
- cpu_rw  in  1  1 = read.
- cpu_addr  in  AW  descrambled address.
- cpu_din  in  DW  data from CPU.
- cpu_dout  out  DW  data to CPU.
- cpu_doe  out  1  data pad output enable.
- cpu_dir  out  1  transceiver direction; 1 = CPU to FPGA.
- cpu_ta_n  out  1  transfer acknowledge, active low.
- cpu_tea_n  out  1  transfer error, active low.
- req_valid  out  1  request valid.
- req_ready  in  1  request accepted.
- req_len  out  4  beat count.
- req_mask  out  DW/8  byte enables; MSB = lowest address.
- req_addr  out  AW  request address.
- req_we  out  1  write request.
- write_valid  out  1  write beat strobe.
- write_data  out  DW  write beat data.
- read_valid  in  1  read beat available.
- read_data  in  DW  read beat data.
- read_err  in  1  qualifies read_valid as an error beat.
- read_ack  out  1  read beat consumed.
- irq_req  in  1  interrupt pending.
- irq_vec  in  8  interrupt vector.
- irq_ack  out  1  acknowledge cycle in progress.

Behaviour:
- Reset: all outputs asserted immediately on rst_ni low:
  - cpu_ta_n = 1, cpu_tea_n = 1, cpu_dir = 1, cpu_doe = 0;
  - req_valid, write_valid, read_ack, irq_ack = 0;
  - state = IDLE; boot counter = 0; watchdog = 0.
- Reset mid-transfer abandons the transfer without completion.
- IDLE, on samp_i with cpu_ts_n = 0:
  - tt = 00 or 01:
    - latch req_addr, req_we = ~cpu_rw, req_len = 1 (LINE_BEATS if siz = 11);
    - assert req_valid; go to REQ.
  - tt = 11: irq_ack = 1; go to IRQ_WAIT.
  - tt = 10: ignored; stay in IDLE.
- Byte-enable mask, with NB = DW/8, s = size bytes (1, 2, 4, or NB for line), o = cpu_addr[log2 NB - 1:0] aligned down to s:
  - req_mask = ((1<<s)-1) << (NB-s-o).
  - Long on DW = 64 is the aligned half; line is all ones.
- Boot remap: while boot counter < BOOT_ACCESSES:
  - req_addr = {ROM_OFF, cpu_addr[15:0]};
  - counter increments per accepted start and saturates.
- REQ: hold req_valid until req_ready; req_valid drops the cycle after the handshake. Then go to RD_TURN (read) or WR_ACK (write).
- RD_TURN: on drv_i, cpu_dir = 0; go to RD_BEAT.
- RD_BEAT: on drv_i with read_valid:
  - cpu_dout = read_data, cpu_doe = 1, read_ack = 1 for one clk;
  - if read_err: cpu_tea_n = 0 and go to ERR;
  - else cpu_ta_n = 0 and go to RD_END.
- RD_END: on drv_i, release TA.
  - Remaining length 1: cpu_doe = 0, cpu_dir = 1; go to IDLE.
  - Otherwise: decrement req_len; go to RD_BEAT.
- WR_ACK: on drv_i, cpu_ta_n = 0; go to WR_BEAT.
- WR_BEAT: on samp_i, write_valid = 1 for one clk with write_data = cpu_din; go to WR_END.
- WR_END: on drv_i.
  - Last beat: release TA; go to IDLE.
  - Otherwise: decrement req_len; go to WR_BEAT.
- IRQ_WAIT: when irq_req & irq_ack, latch vector into the low 8 bits of cpu_dout (rest zero), irq_ack = 0, cpu_dir = 0; go to IRQ_DRV.
- IRQ_DRV: on drv_i, cpu_doe = 1, cpu_ta_n = 0; go to IRQ_END.
- IRQ_END: on drv_i, release TA/doe/dir; go to IDLE.
- ERR: on drv_i, release TEA, doe and dir; drop remaining burst beats; go to IDLE.
- Watchdog:
  - counts drv_i strobes in REQ, RD_BEAT and IRQ_WAIT; clears on every state change.
  - On reaching TIMEOUT: req_valid = 0, irq_ack = 0, cpu_tea_n = 0; go to ERR.
  - A handshake in the same cycle as the timeout wins.
- TA and TEA are never asserted together.
- write_valid and read_ack are single-cycle pulses.

Decomposition:
- Package cpu_bus_pkg: state encoding; SIZ_* and TT_* constants; mask function.
- Sub-module cpu_bus_wdog: watchdog counter with clear/enable/expire.

Test Plan:
- Byte read, addr 0x00000003, DW = 32, after boot → req_mask = 0001, req_len = 1; one TA with cpu_dout = read_data.
- Line write at 0x1000, LINE_BEATS = 4 → 4 write_valid pulses with data in order; TA held through the burst, released after beat 4.
- First two reads at 0x00001234, BOOT_ACCESSES = 2 → req_addr = 0xF0001234; the third read issues 0x00001234.
- IACK with irq_vec = 0x45 → cpu_dout = 0x00000045; one TA; irq_ack low afterwards.
- Line read with read_err on beat 2 → TA on beat 1, TEA on beat 2, no further beats; back in IDLE.
- req_ready held low, TIMEOUT = 8 → TEA after 8 drv_i strobes; req_valid = 0; the next ts is accepted normally.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 68040-style CPU bus slave: FSM state codes,
// transfer size/type encodings and the byte-enable helper.
package cpu_bus_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_REQ      = 4'd1;
  localparam state_t ST_RD_TURN  = 4'd2;
  localparam state_t ST_RD_BEAT  = 4'd3;
  localparam state_t ST_RD_END   = 4'd4;
  localparam state_t ST_WR_ACK   = 4'd5;
  localparam state_t ST_WR_BEAT  = 4'd6;
  localparam state_t ST_WR_END   = 4'd7;
  localparam state_t ST_IRQ_WAIT = 4'd8;
  localparam state_t ST_IRQ_DRV  = 4'd9;
  localparam state_t ST_IRQ_END  = 4'd10;
  localparam state_t ST_ERR      = 4'd11;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam logic [1:0] TT_NORMAL = 2'b00;
  localparam logic [1:0] TT_MOVE16 = 2'b01;
  localparam logic [1:0] TT_ALT    = 2'b10;
  localparam logic [1:0] TT_IACK   = 2'b11;

  // Byte enables for an nb-byte bus, MSB = lowest address; line uses every lane.
  function automatic logic [7:0] byte_mask(input logic [1:0] siz,
                                           input logic [2:0] addr_lo,
                                           input int unsigned nb);
    int unsigned s;
    int unsigned o;
    logic [15:0] ones;
    case (siz)
      SIZ_BYTE: s = 32'd1;
      SIZ_WORD: s = 32'd2;
      SIZ_LONG: s = 32'd4;
      default:  s = nb;
    endcase
    o    = {29'd0, addr_lo} % nb;
    o    = o - (o % s);
    ones = (16'd1 << s) - 16'd1;
    return ones[7:0] << (nb - s - o);
  endfunction

endpackage

// File: rtl/cpu_bus_wdog.sv
// Watchdog for the bus slave: counts drv strobes while a wait state is
// active and flags expiry on the strobe that reaches TIMEOUT.
module cpu_bus_wdog #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] cnt_r;

  // Strobe counter, held at zero outside the watched states.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // TIMEOUT of zero disables the watchdog entirely.
  always_comb begin
    expire = (TIMEOUT != 0) && !clr && en && (cnt_r == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// 68040-style CPU bus slave: turns CPU transfer starts into SoC request,
// write and read streams and returns TA/TEA on the bclk phase strobes.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int              DW            = 32,
  parameter int              AW            = 32,
  parameter int              LINE_BEATS    = 4,
  parameter int              BOOT_ACCESSES = 2,
  parameter logic [AW-17:0]  ROM_OFF       = (AW-16)'(16'hF000),
  parameter int              TIMEOUT       = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            samp_i,
  input  logic            drv_i,
  input  logic            cpu_ts_n,
  input  logic [1:0]      cpu_tt,
  input  logic [1:0]      cpu_siz,
  input  logic            cpu_rw,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_din,
  output logic [DW-1:0]   cpu_dout,
  output logic            cpu_doe,
  output logic            cpu_dir,
  output logic            cpu_ta_n,
  output logic            cpu_tea_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [3:0]      req_len,
  output logic [DW/8-1:0] req_mask,
  output logic [AW-1:0]   req_addr,
  output logic            req_we,
  output logic            write_valid,
  output logic [DW-1:0]   write_data,
  input  logic            read_valid,
  input  logic [DW-1:0]   read_data,
  input  logic            read_err,
  output logic            read_ack,
  input  logic            irq_req,
  input  logic [7:0]      irq_vec,
  output logic            irq_ack
);

  localparam int NB = DW / 8;

  state_t          state_r;
  logic [7:0]      boot_cnt_r;
  logic            boot_remap_s;
  logic [AW-1:0]   start_addr_s;
  logic [NB-1:0]   mask_s;
  logic            wd_clr_s;
  logic            wd_expire_s;

  // Start decode: boot remap address and byte enables for the pending transfer.
  always_comb begin
    boot_remap_s = (boot_cnt_r < 8'(BOOT_ACCESSES));
    start_addr_s = boot_remap_s ? {ROM_OFF, cpu_addr[15:0]} : cpu_addr;
    mask_s       = NB'(byte_mask(cpu_siz, cpu_addr[2:0], NB));
    wd_clr_s     = (state_r != ST_REQ) && (state_r != ST_RD_BEAT) &&
                   (state_r != ST_IRQ_WAIT);
  end

  cpu_bus_wdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (16)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (wd_clr_s),
    .en     (drv_i),
    .expire (wd_expire_s)
  );

  // Transfer FSM with all CPU- and SoC-facing outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      boot_cnt_r  <= 8'd0;
      cpu_dout    <= '0;
      cpu_doe     <= 1'b0;
      cpu_dir     <= 1'b1;
      cpu_ta_n    <= 1'b1;
      cpu_tea_n   <= 1'b1;
      req_valid   <= 1'b0;
      req_len     <= 4'd0;
      req_mask    <= '0;
      req_addr    <= '0;
      req_we      <= 1'b0;
      write_valid <= 1'b0;
      write_data  <= '0;
      read_ack    <= 1'b0;
      irq_ack     <= 1'b0;
    end else begin
      write_valid <= 1'b0;
      read_ack    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (samp_i && !cpu_ts_n) begin
            case (cpu_tt)
              TT_NORMAL, TT_MOVE16: begin
                req_addr  <= start_addr_s;
                req_we    <= !cpu_rw;
                req_len   <= (cpu_siz == SIZ_LINE) ? 4'(LINE_BEATS) : 4'd1;
                req_mask  <= mask_s;
                req_valid <= 1'b1;
                state_r   <= ST_REQ;
                if (boot_remap_s) begin
                  boot_cnt_r <= boot_cnt_r + 8'd1;
                end
              end
              TT_IACK: begin
                irq_ack <= 1'b1;
                state_r <= ST_IRQ_WAIT;
              end
              TT_ALT:  state_r <= ST_IDLE;
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_REQ: begin
          // A handshake coinciding with expiry still proceeds normally.
          if (req_ready) begin
            req_valid <= 1'b0;
            state_r   <= req_we ? ST_WR_ACK : ST_RD_TURN;
          end else if (wd_expire_s) begin
            req_valid <= 1'b0;
            cpu_tea_n <= 1'b0;
            state_r   <= ST_ERR;
          end
        end
        ST_RD_TURN: begin
          if (drv_i) begin
            cpu_dir <= 1'b0;
            state_r <= ST_RD_BEAT;
          end
        end
        ST_RD_BEAT: begin
          if (drv_i && read_valid) begin
            cpu_dout <= read_data;
            cpu_doe  <= 1'b1;
            read_ack <= 1'b1;
            if (read_err) begin
              cpu_tea_n <= 1'b0;
              state_r   <= ST_ERR;
            end else begin
              cpu_ta_n <= 1'b0;
              state_r  <= ST_RD_END;
            end
          end else if (wd_expire_s) begin
            cpu_tea_n <= 1'b0;
            state_r   <= ST_ERR;
          end
        end
        ST_RD_END: begin
          if (drv_i) begin
            cpu_ta_n <= 1'b1;
            if (req_len == 4'd1) begin
              cpu_doe <= 1'b0;
              cpu_dir <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              req_len <= req_len - 4'd1;
              state_r <= ST_RD_BEAT;
            end
          end
        end
        ST_WR_ACK: begin
          if (drv_i) begin
            cpu_ta_n <= 1'b0;
            state_r  <= ST_WR_BEAT;
          end
        end
        ST_WR_BEAT: begin
          if (samp_i) begin
            write_valid <= 1'b1;
            write_data  <= cpu_din;
            state_r     <= ST_WR_END;
          end
        end
        ST_WR_END: begin
          if (drv_i) begin
            if (req_len == 4'd1) begin
              cpu_ta_n <= 1'b1;
              state_r  <= ST_IDLE;
            end else begin
              req_len <= req_len - 4'd1;
              state_r <= ST_WR_BEAT;
            end
          end
        end
        ST_IRQ_WAIT: begin
          if (irq_req && irq_ack) begin
            cpu_dout <= DW'(irq_vec);
            irq_ack  <= 1'b0;
            cpu_dir  <= 1'b0;
            state_r  <= ST_IRQ_DRV;
          end else if (wd_expire_s) begin
            irq_ack   <= 1'b0;
            cpu_tea_n <= 1'b0;
            state_r   <= ST_ERR;
          end
        end
        ST_IRQ_DRV: begin
          if (drv_i) begin
            cpu_doe  <= 1'b1;
            cpu_ta_n <= 1'b0;
            state_r  <= ST_IRQ_END;
          end
        end
        ST_IRQ_END: begin
          if (drv_i) begin
            cpu_ta_n <= 1'b1;
            cpu_doe  <= 1'b0;
            cpu_dir  <= 1'b1;
            state_r  <= ST_IDLE;
          end
        end
        ST_ERR: begin
          // Remaining burst beats are dropped; the CPU sees only the TEA.
          if (drv_i) begin
            cpu_tea_n <= 1'b1;
            cpu_doe   <= 1'b0;
            cpu_dir   <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Randomized bench for cpu_bus_ctrl: acts as CPU and memory, predicting each
// transfer from a transaction-level model of address, mask and beat rules.
module tb_cpu_bus_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int LB   = 4;
  localparam int BOOT = 2;
  localparam int TO   = 8;

  localparam logic [1:0] S_LONG = 2'b00;
  localparam logic [1:0] S_BYTE = 2'b01;
  localparam logic [1:0] S_WORD = 2'b10;
  localparam logic [1:0] S_LINE = 2'b11;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          samp_i = 1'b0;
  logic          drv_i = 1'b0;
  logic          cpu_ts_n = 1'b1;
  logic [1:0]    cpu_tt = 2'b00;
  logic [1:0]    cpu_siz = 2'b00;
  logic          cpu_rw = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] cpu_dout;
  logic          cpu_doe, cpu_dir, cpu_ta_n, cpu_tea_n;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [3:0]    req_len;
  logic [3:0]    req_mask;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic          write_valid;
  logic [DW-1:0] write_data;
  logic          read_valid = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic          read_err = 1'b0;
  logic          read_ack;
  logic          irq_req = 1'b0;
  logic [7:0]    irq_vec = 8'h00;
  logic          irq_ack;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int boot_used = 0;
  int n_rd_ack = 0, n_wr = 0, n_wide = 0, n_both = 0, n_ta = 0;
  logic prev_ra = 1'b0, prev_wv = 1'b0, prev_ta_n = 1'b1;

  cpu_bus_ctrl #(
    .DW(DW), .AW(AW), .LINE_BEATS(LB), .BOOT_ACCESSES(BOOT),
    .ROM_OFF(16'hF000), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .samp_i(samp_i), .drv_i(drv_i),
    .cpu_ts_n(cpu_ts_n), .cpu_tt(cpu_tt), .cpu_siz(cpu_siz), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_doe(cpu_doe), .cpu_dir(cpu_dir), .cpu_ta_n(cpu_ta_n),
    .cpu_tea_n(cpu_tea_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .req_mask(req_mask), .req_addr(req_addr),
    .req_we(req_we), .write_valid(write_valid), .write_data(write_data),
    .read_valid(read_valid), .read_data(read_data), .read_err(read_err),
    .read_ack(read_ack), .irq_req(irq_req), .irq_vec(irq_vec),
    .irq_ack(irq_ack)
  );

  always #5 clk_i = ~clk_i;

  // Protocol monitor: pulse widths, TA/TEA exclusivity, beat and TA counts.
  always @(negedge clk_i) begin
    if (read_ack) n_rd_ack++;
    if (write_valid) n_wr++;
    if (read_ack && prev_ra) n_wide++;
    if (write_valid && prev_wv) n_wide++;
    if (!cpu_ta_n && !cpu_tea_n) n_both++;
    if (!cpu_ta_n && prev_ta_n) n_ta++;
    prev_ra   = read_ack;
    prev_wv   = write_valid;
    prev_ta_n = cpu_ta_n;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock; strobes repeat every 4 clocks: samp at phase 0, drv at phase 2.
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    samp_i = (cyc % 4 == 0);
    drv_i  = (cyc % 4 == 2);
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
    return (boot_used < BOOT) ? {16'hF000, a[15:0]} : a;
  endfunction

  // Lane b (0 = lowest address) enabled when inside the aligned s-byte window.
  function automatic logic [3:0] exp_mask(input logic [1:0] siz, input logic [31:0] a);
    int s, base;
    logic [3:0] m;
    s = (siz == S_BYTE) ? 1 : (siz == S_WORD) ? 2 : 4;
    base = (int'(a[1:0]) / s) * s;
    m = 4'b0000;
    for (int b = 0; b < 4; b++) if (b >= base && b < base + s) m[3-b] = 1'b1;
    return m;
  endfunction

  task automatic start(input logic [1:0] tt, input logic [1:0] siz, input logic rw,
                       input logic [31:0] a);
    int n;
    n = 0;
    while (!samp_i && n < 8) begin step(); n++; end
    cpu_ts_n = 1'b0; cpu_tt = tt; cpu_siz = siz; cpu_rw = rw; cpu_addr = a;
    step();
    cpu_ts_n = 1'b1;
  endtask

  task automatic do_mem(input logic [1:0] siz, input logic rw, input logic [31:0] a,
                        input int err_beat);
    int beats, n, a0, w0;
    logic [31:0] d [LB];
    beats = (siz == S_LINE) ? LB : 1;
    for (int k = 0; k < LB; k++) d[k] = $urandom;
    start({1'b0, 1'($urandom_range(0, 1))}, siz, rw, a);
    check("req_valid", req_valid, 1);
    check("req_addr", req_addr, exp_addr(a));
    check("req_mask", req_mask, exp_mask(siz, a));
    check("req_len", req_len, beats);
    check("req_we", req_we, !rw);
    boot_used++;
    repeat ($urandom_range(0, 4)) step();
    req_ready = 1'b1; step(); req_ready = 1'b0;
    check("req_drop", req_valid, 0);
    a0 = n_rd_ack; w0 = n_wr;
    if (rw) begin
      for (int k = 0; k < beats; k++) begin
        repeat ($urandom_range(0, 5)) step();
        read_valid = 1'b1; read_data = d[k]; read_err = (k == err_beat);
        n = 0;
        do begin step(); n++; end while (!read_ack && n < 64);
        read_valid = 1'b0; read_err = 1'b0;
        check("rd_ack", read_ack, 1);
        check("rd_dout", cpu_dout, d[k]);
        check("rd_doe", cpu_doe, 1);
        check("rd_dir", cpu_dir, 0);
        check("rd_ta_n", cpu_ta_n, k == err_beat);
        check("rd_tea_n", cpu_tea_n, k != err_beat);
        if (k == err_beat) break;
      end
      n = 0;
      while ((!cpu_ta_n || !cpu_tea_n) && n < 64) begin step(); n++; end
      check("rd_end_dir", cpu_dir, 1);
      check("rd_end_doe", cpu_doe, 0);
      check("rd_beats", n_rd_ack - a0,
            (err_beat >= 0 && err_beat < beats) ? err_beat + 1 : beats);
    end else begin
      cpu_din = d[0];
      for (int k = 0; k < beats; k++) begin
        n = 0;
        do begin step(); n++; end while (!write_valid && n < 64);
        check("wr_valid", write_valid, 1);
        check("wr_data", write_data, d[k]);
        check("wr_ta_n", cpu_ta_n, 0);
        if (k + 1 < beats) cpu_din = d[k+1];
      end
      n = 0;
      while (!cpu_ta_n && n < 64) begin step(); n++; end
      check("wr_ta_rel", cpu_ta_n, 1);
      check("wr_beats", n_wr - w0, beats);
    end
  endtask

  task automatic do_iack(input logic [7:0] v);
    int n, t0;
    t0 = n_ta;
    start(2'b11, S_LONG, 1'b1, $urandom);
    check("iack_start", irq_ack, 1);
    check("iack_noreq", req_valid, 0);
    repeat ($urandom_range(0, 5)) step();
    irq_req = 1'b1; irq_vec = v;
    n = 0;
    do begin step(); n++; end while (irq_ack && n < 64);
    irq_req = 1'b0;
    check("iack_drop", irq_ack, 0);
    check("iack_vec", cpu_dout, {24'd0, v});
    check("iack_dir", cpu_dir, 0);
    n = 0;
    while (cpu_ta_n && n < 64) begin step(); n++; end
    check("iack_ta", cpu_ta_n, 0);
    check("iack_doe", cpu_doe, 1);
    n = 0;
    while (!cpu_ta_n && n < 64) begin step(); n++; end
    check("iack_rel", {cpu_ta_n, cpu_doe, cpu_dir, irq_ack}, 4'b1010);
    check("iack_one_ta", n_ta - t0, 1);
  endtask

  task automatic do_timeout(input logic rw);
    int n, ndrv;
    start(2'b00, S_LONG, rw, $urandom);
    check("to_req", req_valid, 1);
    boot_used++;
    n = 0; ndrv = 0;
    while (cpu_tea_n && n < 200) begin
      if (drv_i) ndrv++;
      step(); n++;
    end
    check("to_tea", cpu_tea_n, 0);
    check("to_ndrv", ndrv, TO);
    check("to_req_drop", req_valid, 0);
    check("to_ta", cpu_ta_n, 1);
    n = 0;
    while (!cpu_tea_n && n < 64) begin step(); n++; end
    check("to_tea_rel", cpu_tea_n, 1);
  endtask

  initial begin
    int n;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_cpu", {cpu_ta_n, cpu_tea_n, cpu_dir, cpu_doe}, 4'b1110);
    check("rst_soc", {req_valid, write_valid, read_ack, irq_ack}, 4'b0000);
    step(); step();
    rst_ni = 1'b1;
    step();

    // Boot remap covers the first two starts only.
    do_mem(S_LONG, 1'b1, 32'h0000_1234, -1);
    do_mem(S_LONG, 1'b1, 32'h0000_1234, -1);
    do_mem(S_LONG, 1'b1, 32'h0000_1234, -1);
    do_mem(S_BYTE, 1'b1, 32'h0000_0003, -1);
    do_mem(S_WORD, 1'b0, 32'h0000_0002, -1);
    do_mem(S_LINE, 1'b0, 32'h0000_1000, -1);
    do_iack(8'h45);
    do_mem(S_LINE, 1'b1, 32'h0000_2000, 1);
    do_timeout(1'b1);
    do_mem(S_LONG, 1'b1, 32'h0000_4000, -1);

    // Alternate-space starts are ignored.
    start(2'b10, S_LONG, 1'b1, 32'h0000_5000);
    repeat (8) step();
    check("alt_ignored", {req_valid, irq_ack}, 2'b00);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0: do_mem(2'($urandom_range(0, 2)), 1'b1, $urandom, -1);
        1: do_mem(S_LINE, 1'b1, $urandom,
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : -1);
        2: do_mem(2'($urandom_range(0, 3)), 1'b0, $urandom, -1);
        3: do_iack(8'($urandom));
        default: do_timeout(1'($urandom_range(0, 1)));
      endcase
    end

    // Reset in the middle of a write burst abandons it and restarts boot remap.
    start(2'b00, S_LINE, 1'b0, 32'h0000_6000);
    req_ready = 1'b1; step(); req_ready = 1'b0;
    n = 0;
    while (cpu_ta_n && n < 64) begin step(); n++; end
    check("mid_ta", cpu_ta_n, 0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst", {cpu_ta_n, cpu_tea_n, cpu_dir, cpu_doe, req_valid}, 5'b11100);
    step(); step();
    rst_ni = 1'b1;
    boot_used = 0;
    step();
    do_mem(S_LONG, 1'b1, 32'h0000_1234, -1);

    check("pulse_width", n_wide, 0);
    check("ta_tea_excl", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
